qam_carrier_loop: RTL

Parametrised decision-directed carrier-recovery loop for the 16QAM receiver. It slices filtered baseband I/Q symbols and forms a DD phase error. A PI loop filter with gear-shifted gains turns that error into a signed frequency-correction word for the external NCO's `freq_mod_i` port. A lock-detector FSM selects acquisition or tracking gains. It sits between the I/Q low-pass filters / bit-sync stage and the NCO, and adds QPSK/16QAM mode, loop hold, saturation and lock reporting.

---
 rtl/qam_carrier_loop.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/qam_carrier_loop.sv
// Decision-directed carrier recovery for 16QAM/QPSK: slicer, DD phase detector,
// gear-shifted PI loop filter driving the NCO frequency word, and a window-based lock FSM.
module qam_carrier_loop #(
  parameter int          DW         = 16,
  parameter int          FW         = 34,
  parameter int          KP_ACQ     = 8,
  parameter int          KI_ACQ     = 14,
  parameter int          KP_TRK     = 12,
  parameter int          KI_TRK     = 20,
  parameter int          WIN_LOG    = 6,
  parameter logic [63:0] LOCK_THR   = 64'd1073741824,
  parameter int          LOCK_CNT   = 4,
  parameter int          UNLOCK_CNT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bitsync_i,
  input  logic signed [DW-1:0] yi_i,
  input  logic signed [DW-1:0] yq_i,
  input  logic                 mode_i,
  input  logic                 hold_i,
  output logic signed [FW-1:0] df_o,
  output logic                 df_valid_o,
  output logic signed [2*DW:0] pd_o,
  output logic [1:0]           state_o,
  output logic                 lock_o
);
  localparam int PW = 2*DW + 1;
  localparam int MW = PW + WIN_LOG;
  localparam int SW = ((PW > FW) ? PW : FW) + 2;
  localparam logic [DW-1:0] A1 = {3'b001, {(DW-3){1'b0}}};
  localparam logic [DW-1:0] A2 = {3'b010, {(DW-3){1'b0}}};
  localparam logic [DW-1:0] A3 = {3'b011, {(DW-3){1'b0}}};
  localparam logic signed [SW-1:0] MAXV = {{(SW-FW+1){1'b0}}, {(FW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-FW+1){1'b1}}, {(FW-1){1'b0}}};
  localparam logic [7:0] LOCK_N   = 8'(LOCK_CNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_CNT);

  typedef enum logic [1:0] {ACQ = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_e;

  function automatic logic [DW-1:0] slice(input logic [DW-1:0] y, input logic qam16);
    logic [DW:0]   mag_y;
    logic [DW-1:0] mag;
    mag_y = y[DW-1] ? (~{1'b1, y} + {{DW{1'b0}}, 1'b1}) : {1'b0, y};
    if (!qam16)                  mag = A2;
    else if (mag_y < {1'b0, A2}) mag = A1;
    else                         mag = A3;
    slice = y[DW-1] ? (~mag + {{(DW-1){1'b0}}, 1'b1}) : mag;
  endfunction

  function automatic logic [FW-1:0] sat(input logic signed [SW-1:0] x);
    if (x > MAXV)      sat = MAXV[FW-1:0];
    else if (x < MINV) sat = MINV[FW-1:0];
    else               sat = x[FW-1:0];
  endfunction

  logic signed [DW-1:0] yi_q, yq_q, di_q, dq_q;
  logic                 v1_q, h1_q, v2_q, h2_q, df_valid_q, lock_q;
  logic signed [PW-1:0] pd_q;
  logic signed [FW-1:0] integ_q, df_q;
  logic [MW-1:0]        m_q;
  logic [WIN_LOG-1:0]   wcnt_q;
  logic [7:0]           gcnt_q, bcnt_q;
  state_e               state_q;

  logic signed [PW-1:0] yi_x_s, yq_x_s, di_x_s, dq_x_s, pd_s;
  logic signed [SW-1:0] pd_x_s, p_sh_s, i_sh_s, isum_s, dsum_s;
  logic signed [FW-1:0] integ_d, df_d;
  logic [PW-1:0]        apd_s;
  logic [MW-1:0]        msum_s;
  logic                 trk_s, upd_s, win_end_s, good_s;

  assign yi_x_s = {{(PW-DW){yi_q[DW-1]}}, yi_q};
  assign yq_x_s = {{(PW-DW){yq_q[DW-1]}}, yq_q};
  assign di_x_s = {{(PW-DW){di_q[DW-1]}}, di_q};
  assign dq_x_s = {{(PW-DW){dq_q[DW-1]}}, dq_q};
  assign pd_s   = yq_x_s * di_x_s - yi_x_s * dq_x_s;

  // Gains follow the state current when the symbol reaches the filter stage
  assign trk_s   = (state_q != ACQ);
  assign pd_x_s  = {{(SW-PW){pd_q[PW-1]}}, pd_q};
  assign p_sh_s  = trk_s ? (pd_x_s >>> KP_TRK) : (pd_x_s >>> KP_ACQ);
  assign i_sh_s  = trk_s ? (pd_x_s >>> KI_TRK) : (pd_x_s >>> KI_ACQ);
  assign isum_s  = {{(SW-FW){integ_q[FW-1]}}, integ_q} + i_sh_s;
  assign integ_d = sat(isum_s);
  assign dsum_s  = p_sh_s + {{(SW-FW){integ_d[FW-1]}}, integ_d};
  assign df_d    = sat(dsum_s);

  assign apd_s     = pd_q[PW-1] ? (~pd_q + {{(PW-1){1'b0}}, 1'b1}) : pd_q;
  assign msum_s    = m_q + {{(MW-PW){1'b0}}, apd_s};
  assign good_s    = ({{(64-MW){1'b0}}, msum_s} < LOCK_THR);
  assign upd_s     = v2_q & ~h2_q;
  assign win_end_s = upd_s & (&wcnt_q);

  // Three-stage symbol pipeline: slice, phase detect, loop filter and metric
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q <= 1'b0; h1_q <= 1'b0; v2_q <= 1'b0; h2_q <= 1'b0;
      yi_q <= {DW{1'b0}}; yq_q <= {DW{1'b0}}; di_q <= {DW{1'b0}}; dq_q <= {DW{1'b0}};
      pd_q <= {PW{1'b0}}; integ_q <= {FW{1'b0}}; df_q <= {FW{1'b0}};
      df_valid_q <= 1'b0; m_q <= {MW{1'b0}}; wcnt_q <= {WIN_LOG{1'b0}};
    end else begin
      v1_q <= bitsync_i;
      if (bitsync_i) begin
        yi_q <= yi_i;
        yq_q <= yq_i;
        di_q <= slice(yi_i, mode_i);
        dq_q <= slice(yq_i, mode_i);
        h1_q <= hold_i;
      end
      v2_q <= v1_q;
      h2_q <= h1_q;
      if (v1_q) pd_q <= pd_s;
      df_valid_q <= upd_s;
      if (upd_s) begin
        integ_q <= integ_d;
        df_q    <= df_d;
        wcnt_q  <= wcnt_q + {{(WIN_LOG-1){1'b0}}, 1'b1};
        m_q     <= win_end_s ? {MW{1'b0}} : msum_s;
      end
    end
  end

  // Lock FSM, stepped once per completed window
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ACQ; gcnt_q <= 8'd0; bcnt_q <= 8'd0; lock_q <= 1'b0;
    end else if (win_end_s) begin
      case (state_q)
        ACQ: begin
          gcnt_q <= 8'd0;
          bcnt_q <= 8'd0;
          if (good_s) state_q <= TRACK;
          else        state_q <= ACQ;
        end
        TRACK: begin
          if (!good_s) begin
            state_q <= ACQ;
            gcnt_q  <= 8'd0;
          end else if (gcnt_q == LOCK_N - 8'd1) begin
            state_q <= LOCKED;
            lock_q  <= 1'b1;
            gcnt_q  <= 8'd0;
            bcnt_q  <= 8'd0;
          end else begin
            gcnt_q <= gcnt_q + 8'd1;
          end
        end
        LOCKED: begin
          if (good_s) begin
            bcnt_q <= 8'd0;
          end else if (bcnt_q == UNLOCK_N - 8'd1) begin
            state_q <= ACQ;
            lock_q  <= 1'b0;
            bcnt_q  <= 8'd0;
          end else begin
            bcnt_q <= bcnt_q + 8'd1;
          end
        end
        default: begin
          state_q <= ACQ; lock_q <= 1'b0; gcnt_q <= 8'd0; bcnt_q <= 8'd0;
        end
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  assign df_o       = df_q;
  assign df_valid_o = df_valid_q;
  assign pd_o       = pd_q;
  assign state_o    = state_q;
  assign lock_o     = lock_q;
endmodule
